train_sequencer: RTL and testbench

//  Train controller FSM sitting directly upstream of the Timer stage.

---
 rtl/train_sequencer.sv | 159 +++++++++++++++
 tb/tb_train_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/train_sequencer.sv
// Train trip controller: walks accelerate/cruise/brake/doors/dwell and hands durations to the Timer stage.
// Optional DOOR_RETRY_LIMIT_EN adds a door reopen counter and a latched FAULT state.
module train_sequencer #(
    parameter logic [18:0] T_ACCEL = 19'd200000,
    parameter logic [18:0] T_DECEL = 19'd150000,
    parameter logic [18:0] T_DOOR  = 19'd50000,
    parameter logic [18:0] T_DWELL = 19'd300000
`ifdef DOOR_RETRY_LIMIT_EN
    ,
    parameter int MAX_RETRY = 3
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        station_sensor,
    input  logic        door_obstruct,
    input  logic        emergency,
    input  logic        timer_done,
    output logic [18:0] t,
    output logic [3:0]  present_state,
    output logic        motor_en,
    output logic        brake,
    output logic        door_open,
    output logic        alarm
);

    // state      | meaning
    // IDLE       | stopped at station, waiting for start
    // ACCEL      | traction on for T_ACCEL
    // CRUISE     | traction on until station_sensor
    // DECEL      | braking for T_DECEL
    // DOOR_OPEN  | doors travelling open for T_DOOR
    // DWELL      | doors open for T_DWELL
    // DOOR_CLOSE | doors travelling closed for T_DOOR, reopen on obstruction
    // EMERG      | emergency stop until emergency drops
    // FAULT      | too many reopens, left only by rst
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ACCEL      = 4'd1,
        CRUISE     = 4'd2,
        DECEL      = 4'd3,
        DOOR_OPEN  = 4'd4,
        DWELL      = 4'd5,
        DOOR_CLOSE = 4'd6,
        EMERG      = 4'd7,
        FAULT      = 4'd8
    } state_t;

    state_t     state;
    state_t     nxt;
    logic       reopen;
    logic       entered;
    logic       exp_ok;
    logic       pending;
    logic [1:0] guard;
`ifdef DOOR_RETRY_LIMIT_EN
    logic [1:0] retry;
`endif

    function automatic logic is_load(state_t s);
        return (s == ACCEL) || (s == DECEL) || (s == DOOR_OPEN) ||
               (s == DWELL) || (s == DOOR_CLOSE);
    endfunction

    function automatic logic [18:0] dur_of(state_t s);
        case (s)
            ACCEL:                 return T_ACCEL;
            DECEL:                 return T_DECEL;
            DOOR_OPEN, DOOR_CLOSE: return T_DOOR;
            DWELL:                 return T_DWELL;
            default:               return 19'd0;
        endcase
    endfunction

    assign present_state = state;

    // guard hides timer_done for three cycles after each load so a stale done is not taken as expiry
    always_comb begin
        exp_ok = timer_done && (guard == 2'd0);
        nxt    = state;
        reopen = 1'b0;
        if (emergency && (state != IDLE) && (state != EMERG) && (state != FAULT)) begin
            nxt = EMERG;
        end else begin
            case (state)
                IDLE:      if (start)          nxt = ACCEL;
                ACCEL:     if (exp_ok)         nxt = CRUISE;
                CRUISE:    if (station_sensor) nxt = DECEL;
                DECEL:     if (exp_ok)         nxt = DOOR_OPEN;
                DOOR_OPEN: if (exp_ok)         nxt = DWELL;
                DWELL:     if (exp_ok)         nxt = DOOR_CLOSE;
                DOOR_CLOSE: begin
                    if (door_obstruct) begin
`ifdef DOOR_RETRY_LIMIT_EN
                        if (retry == 2'(MAX_RETRY)) begin
                            nxt = FAULT;
                        end else begin
                            nxt    = DOOR_OPEN;
                            reopen = 1'b1;
                        end
`else
                        nxt    = DOOR_OPEN;
                        reopen = 1'b1;
`endif
                    end else if (exp_ok) begin
                        nxt = IDLE;
                    end
                end
                EMERG:     if (!emergency)     nxt = IDLE;
                default:   nxt = state;
            endcase
        end
        entered = (nxt != state) || reopen;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            t         <= 19'd0;
            guard     <= 2'd0;
            pending   <= 1'b0;
            motor_en  <= 1'b0;
            brake     <= 1'b0;
            door_open <= 1'b0;
            alarm     <= 1'b0;
`ifdef DOOR_RETRY_LIMIT_EN
            retry     <= 2'd0;
`endif
        end else begin
            state <= nxt;
            // two-cycle load: zero on entry, duration one cycle later
            if (entered) begin
                t       <= 19'd0;
                pending <= is_load(nxt);
            end else if (pending) begin
                t       <= dur_of(state);
                pending <= 1'b0;
            end
            if (entered && is_load(nxt)) begin
                guard <= 2'd3;
            end else if (guard != 2'd0) begin
                guard <= guard - 2'd1;
            end
            motor_en  <= (nxt == ACCEL) || (nxt == CRUISE);
            brake     <= !((nxt == ACCEL) || (nxt == CRUISE));
            door_open <= (nxt == DOOR_OPEN) || (nxt == DWELL);
            alarm     <= (nxt == EMERG) || (nxt == FAULT);
`ifdef DOOR_RETRY_LIMIT_EN
            if (reopen) begin
                retry <= retry + 2'd1;
            end else if ((state == DOOR_CLOSE) && (nxt == IDLE)) begin
                retry <= 2'd0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_train_sequencer.sv
// Bench for train_sequencer: directed trip scenarios plus randomized inputs,
// all checked every cycle against a cycles-since-entry model of the trip rules.
module tb_train_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        station_sensor = 1'b0;
    logic        door_obstruct = 1'b0;
    logic        emergency = 1'b0;
    logic        timer_done = 1'b0;
    logic [18:0] t;
    logic [3:0]  present_state;
    logic        motor_en;
    logic        brake;
    logic        door_open;
    logic        alarm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    train_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .station_sensor (station_sensor),
        .door_obstruct  (door_obstruct),
        .emergency      (emergency),
        .timer_done     (timer_done),
        .t              (t),
        .present_state  (present_state),
        .motor_en       (motor_en),
        .brake          (brake),
        .door_open      (door_open),
        .alarm          (alarm)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int target, input string name);
        for (int i = 0; i < 60 && int'(present_state) != target; i++) tick();
        chk(name, int'(present_state), target);
    endtask

    // ---------------- reference model ----------------
    int m_st = 0;
    int m_age = 0;
    int m_retry = 0;
    bit m_zero = 1'b1;
    bit m_valid = 1'b0;

    function automatic bit loads(input int s);
        return s == 1 || s == 3 || s == 4 || s == 5 || s == 6;
    endfunction

    function automatic int dur(input int s);
        case (s)
            1:       return 200000;
            3:       return 150000;
            4, 6:    return 50000;
            5:       return 300000;
            default: return 0;
        endcase
    endfunction

    initial begin
        int nst;
        bit ex;
        bit re;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_st = 0; m_age = 0; m_retry = 0; m_zero = 1'b1; m_valid = 1'b1;
            end else if (m_valid) begin
                ex  = timer_done && (m_age >= 3);
                nst = m_st;
                re  = 1'b0;
                if (emergency && m_st != 0 && m_st != 7 && m_st != 8) nst = 7;
                else begin
                    case (m_st)
                        0: if (start) nst = 1;
                        1: if (ex) nst = 2;
                        2: if (station_sensor) nst = 3;
                        3: if (ex) nst = 4;
                        4: if (ex) nst = 5;
                        5: if (ex) nst = 6;
                        6: begin
                            if (door_obstruct) begin
`ifdef DOOR_RETRY_LIMIT_EN
                                if (m_retry == 3) nst = 8;
                                else begin nst = 4; re = 1'b1; m_retry++; end
`else
                                nst = 4; re = 1'b1;
`endif
                            end else if (ex) begin
                                nst = 0; m_retry = 0;
                            end
                        end
                        7: if (!emergency) nst = 0;
                        default: nst = m_st;
                    endcase
                end
                if (nst != m_st || re) m_age = 0;
                else if (m_age < 7) m_age++;
                m_st = nst;
                m_zero = 1'b0;
            end
            @(negedge clk);
            if (m_valid) begin
                chk("m_state", int'(present_state), m_st);
                chk("m_t", int'(t), (!m_zero && loads(m_st) && m_age >= 1) ? dur(m_st) : 0);
                chk("m_motor", int'(motor_en), int'(!m_zero && (m_st == 1 || m_st == 2)));
                chk("m_brake", int'(brake), int'(!m_zero && !(m_st == 1 || m_st == 2)));
                chk("m_door", int'(door_open), int'(!m_zero && (m_st == 4 || m_st == 5)));
                chk("m_alarm", int'(alarm), int'(!m_zero && (m_st == 7 || m_st == 8)));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // reset state and first load
        rst = 1'b1; tick();
        chk("rst_state", int'(present_state), 0);
        chk("rst_t", int'(t), 0);
        chk("rst_brake", int'(brake), 0);
        rst = 1'b0; start = 1'b1; timer_done = 1'b1; tick();
        chk("start_state", int'(present_state), 1);
        chk("start_motor", int'(motor_en), 1);
        chk("start_t0", int'(t), 0);
        start = 1'b0; tick();
        chk("accel_t", int'(t), 200000);
        tick(); tick();
        chk("guard_hold", int'(present_state), 1);
        tick();
        chk("to_cruise", int'(present_state), 2);
        chk("cruise_t", int'(t), 0);

        // emergency in CRUISE
        emergency = 1'b1; tick();
        chk("emerg_state", int'(present_state), 7);
        chk("emerg_alarm", int'(alarm), 1);
        chk("emerg_brake", int'(brake), 1);
        chk("emerg_motor", int'(motor_en), 0);
        emergency = 1'b0; tick();
        chk("emerg_exit", int'(present_state), 0);

        // full trip with a reopen
        start = 1'b1; timer_done = 1'b1; station_sensor = 1'b0;
        run_until(1, "trip_accel");
        start = 1'b0;
        run_until(2, "trip_cruise");
        station_sensor = 1'b1;
        run_until(3, "trip_decel");
        station_sensor = 1'b0;
        run_until(4, "trip_door_open");
        chk("door_open_4", int'(door_open), 1);
        run_until(5, "trip_dwell");
        chk("door_open_5", int'(door_open), 1);
        run_until(6, "trip_door_close");
        chk("door_open_6", int'(door_open), 0);
        timer_done = 1'b0; tick();
        chk("close_t", int'(t), 50000);
        door_obstruct = 1'b1; tick();
        chk("reopen_state", int'(present_state), 4);
        chk("reopen_t0", int'(t), 0);
        door_obstruct = 1'b0; tick();
        chk("reopen_t", int'(t), 50000);
        timer_done = 1'b1;
        run_until(6, "reclose");
        run_until(0, "trip_idle");

        // repeated obstruction in one stop
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; station_sensor = 1'b1; timer_done = 1'b1;
        run_until(1, "ob_accel");
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_until(6, "ob_close");
            door_obstruct = 1'b1; tick(); door_obstruct = 1'b0;
        end
`ifdef DOOR_RETRY_LIMIT_EN
        chk("fault_state", int'(present_state), 8);
        chk("fault_alarm", int'(alarm), 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("fault_sticky", int'(present_state), 8);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("fault_rst", int'(present_state), 0);
`else
        chk("no_fault", int'(present_state), 4);
        chk("no_fault_door", int'(door_open), 1);
`endif

        // reset in DWELL
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; station_sensor = 1'b1; timer_done = 1'b1;
        run_until(5, "pre_rst_dwell");
        start = 1'b0;
        rst = 1'b1; tick();
        chk("dwell_rst_state", int'(present_state), 0);
        chk("dwell_rst_t", int'(t), 0);
        chk("dwell_rst_outs", int'({motor_en, brake, door_open, alarm}), 0);
        rst = 1'b0;

        // randomized operation
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 399) == 0);
            start          = ($urandom_range(0, 3) == 0);
            station_sensor = ($urandom_range(0, 2) == 0);
            door_obstruct  = ($urandom_range(0, 7) == 0);
            emergency      = ($urandom_range(0, 59) == 0);
            timer_done     = ($urandom_range(0, 2) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; emergency = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
